// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for pipeline stage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   // Canonical NOP (addi x0,x0,0) for BUBBLE at instantiation sites
   localparam logic [63:0] PIPE_NOP = 64'h0000_0000_0000_0013;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that increments on inc and sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Valid/ready pipeline stage with two-entry skid buffer, flush
//                with bubble injection and saturating stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W = 64,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter int                CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              out_valid_q;
   logic              in_ready_q;

   logic w_in_fire;
   logic w_out_fire;

   assign w_in_fire  = in_valid & in_ready_q;
   assign w_out_fire = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Any payload accepted this cycle is discarded along with held ones
         state_d = ST_EMPTY;
         main_d  = BUBBLE;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  main_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               unique case ({w_in_fire, w_out_fire})
                  2'b11: main_d = in_data;
                  2'b10: begin
                     skid_d  = in_data;
                     state_d = ST_FULL;
                  end
                  2'b01: state_d = ST_EMPTY;
                  default: ;
               endcase
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = BUBBLE;
            end
         endcase
      end
   end

   // Handshake outputs are registered from the next state so that no
   // combinational path exists from out_ready or flush to any output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         main_q      <= BUBBLE;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= (state_d != ST_EMPTY);
         in_ready_q  <= (state_d != ST_FULL);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (out_valid_q & ~out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush),
      .count (flush_cnt)
   );

endmodule : pipe_skid_reg
`default_nettype wire

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a two-entry skid buffer, valid/ready handshakes on both sides, synchronous flush with bubble injection, and saturating stall/flush performance counters. It replaces fixed-width, stall-gated stage registers (first use: between fetch and decode, carrying PC+4 and instruction). Every pipeline boundary in the core is built from it. Because the skid entry makes `in_ready` a registered signal, upstream ready-paths are cut.

## Interface
- `DATA_W`, default 64: payload width (for example PC+4 concatenated with the instruction).
- `BUBBLE`, default 0: value driven on `out_data` after reset or flush (a NOP encoding).
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents a payload.
- `in_data`  in  DATA_W  upstream payload.
- `in_ready`  out  1  stage can accept; a registered output.
- `out_valid`  out  1  stage holds a payload for downstream.
- `out_data`  out  DATA_W  payload presented to downstream.
- `out_ready`  in  1  downstream accepts.
- `flush`  in  1  synchronous kill of all held and incoming payloads.
- `stall_cnt`  out  CNT_W  cycles with `out_valid & !out_ready`, saturating.
- `flush_cnt`  out  CNT_W  cycles with `flush` high, saturating.

## Operation
- Transfer definitions: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: main register (drives `out_data`) plus one skid register.
- The state machine has three states:
  - EMPTY: both entries invalid.
  - ONE: main register valid.
  - FULL: main and skid registers both valid.
- `out_valid` = state != EMPTY.
- `in_ready` = state != FULL, registered with the state.
- EMPTY:
  - on `in_fire`: main <= `in_data`, go to ONE.
  - otherwise stay in EMPTY.
- ONE:
  - `in_fire & out_fire`: main <= `in_data`, stay in ONE.
  - `in_fire & !out_fire`: skid <= `in_data`, go to FULL.
  - `!in_fire & out_fire`: go to EMPTY; `out_data` holds its last value.
  - neither: hold.
- FULL (no input accepted):
  - on `out_fire`: main <= skid, go to ONE.
  - otherwise hold.
- `flush` has top priority over every transition:
  - next state is EMPTY and main <= BUBBLE.
  - Any `in_fire` in the flush cycle is discarded.
  - An `out_fire` in the flush cycle still completes downstream, because it was presented in that cycle.
- Ordering is strictly FIFO: the skid payload is never overtaken.
- Counters:
  - Each increments by 1 per qualifying cycle.
  - Each holds at 2^CNT_W−1 and never wraps.
  - A flush does not clear the counters; only reset does.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream) sets:
  - state EMPTY, so `out_valid`=0 and `in_ready`=1
  - `out_data`=BUBBLE; skid contents don't-care
  - `stall_cnt`=0, `flush_cnt`=0
- Latency: in EMPTY or ONE-with-drain, payload accepted at edge N is valid on `out_data` after edge N, i.e. one cycle.
- Throughput: one payload per cycle while `out_ready`=1.
- Bubble cost after a downstream stall releases: zero, because the skid register drains the next cycle.
- `in_ready` falls the cycle after the skid register fills. It rises the cycle after a FULL→ONE drain.
- Combinational paths:
  - No combinational path from `out_ready` to `in_ready`.
  - `flush` affects outputs only after the clock edge.
- Reset asserted mid-transfer: both entries are dropped immediately and asynchronously; outputs take their reset values without waiting for `clk`.
- `in_data` must be stable only while `in_valid`=1. `in_valid` may drop without a handshake; the stage does not require upstream to hold it.

## Structure
- Shared package `pipe_pkg`:
  - state enum {EMPTY, ONE, FULL}
  - default NOP constant used for `BUBBLE` at instantiation sites
- Sub-module `sat_counter` (parameter W; ports `clk`, `rst_n`, `inc`, `count`), instantiated twice for the two performance counters.
- The remainder is a single always block for state and data registers, plus next-state logic.

## Test plan
- Reset, then stream 0x11, 0x22, 0x33 with `out_ready`=1 → each appears one cycle later; `in_ready` stays 1; `stall_cnt`=0.
- Send 0xA then 0xB while `out_ready`=0 → state FULL and `in_ready`=0 on the next cycle. Raise `out_ready` → 0xA then 0xB are output in consecutive cycles; `stall_cnt`=2 (cycles with `out_valid` high and no acceptance).
- In FULL, assert `flush` with `in_valid`=1 and `in_data`=0xC → next cycle `out_valid`=0, `out_data`=BUBBLE, `in_ready`=1; 0xC is never output; `flush_cnt`=1.
- With CNT_W=2, hold `out_valid`=1 and `out_ready`=0 for 6 cycles → `stall_cnt` reaches 3 and stays at 3.
- Deassert `rst_n` between clock edges while FULL → outputs take their reset values immediately. After release, the first accepted input 0x5 appears with one-cycle latency.
- Random valid/ready toggling with 1000 payloads against a FIFO scoreboard → no loss, no duplication, order preserved, and `in_ready` never depends combinationally on `out_ready`.
